// File: rtl/xoodyak_text_unload.sv
// Xoodyak result unloader: 4-block FIFO drained as 32-bit words, MS word first.
// Define XOODYAK_TAGCHK_EN to compile in tag verification (tag_ok/tag_fail).
module xoodyak_text_unload (
    input  logic         eph1,
    input  logic         reset,
    input  logic [191:0] textout_r,
    input  logic         textout_valid,
    input  logic [1:0]   textout_kind,
    input  logic [2:0]   textout_len,
    input  logic [127:0] expected_tag,
    output logic [31:0]  dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         dout_last,
    output logic [1:0]   dout_kind,
    output logic         fifo_full,
    output logic         overflow,
    output logic         tag_ok,
    output logic         tag_fail
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t state_q, state_d;

    logic [191:0] data_q [4];
    logic [1:0]   kind_q [4];
    logic [2:0]   len_q  [4];

    logic [2:0]   count_q, count_d;
    logic [1:0]   wr_ptr_q, rd_ptr_q;
    logic [2:0]   word_cnt_q;
    logic         overflow_q;

    logic         push, accept, pop;
    logic [2:0]   len_n;
    logic [1:0]   kind_n;
    logic [191:0] head;
    logic [31:0]  head_word;

    assign fifo_full = (count_q == 3'd4);
    assign push      = textout_valid & ~fifo_full;
    assign len_n     = (textout_len == 3'd0 || textout_len == 3'd7)
                       ? 3'd6 : textout_len;
    // Reserved kind 3 is stored as squeeze so consumers only see 0..2
    assign kind_n    = (textout_kind == 2'd3) ? 2'd1 : textout_kind;

    assign dout_valid = (state_q == EMIT);
    assign head       = data_q[rd_ptr_q];
    assign dout_last  = dout_valid
                        && (word_cnt_q == len_q[rd_ptr_q] - 3'd1);
    assign dout_kind  = dout_valid ? kind_q[rd_ptr_q] : 2'd0;
    assign dout       = dout_valid ? head_word : 32'd0;
    assign accept     = dout_valid & dout_ready;
    assign pop        = accept & dout_last;
    assign overflow   = overflow_q;

    always_comb begin
        head_word = 32'd0;
        unique case (word_cnt_q)
            3'd0:    head_word = head[191:160];
            3'd1:    head_word = head[159:128];
            3'd2:    head_word = head[127:96];
            3'd3:    head_word = head[95:64];
            3'd4:    head_word = head[63:32];
            3'd5:    head_word = head[31:0];
            default: head_word = 32'd0;
        endcase
    end

    always_comb begin
        count_d = count_q + {2'b00, push} - {2'b00, pop};
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (push) state_d = EMIT;
            EMIT:    if (pop && !push && count_q == 3'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge eph1) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage needs no reset: the cleared count makes old entries invisible
    always_ff @(posedge eph1) begin
        if (push) begin
            data_q[wr_ptr_q] <= textout_r;
            kind_q[wr_ptr_q] <= kind_n;
            len_q[wr_ptr_q]  <= len_n;
        end
    end

    always_ff @(posedge eph1) begin
        if (reset) begin
            count_q    <= 3'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            word_cnt_q <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 2'd1;
                word_cnt_q <= 3'd0;
            end else if (accept) begin
                word_cnt_q <= word_cnt_q + 3'd1;
            end
            if (textout_valid && fifo_full) overflow_q <= 1'b1;
        end
    end

`ifdef XOODYAK_TAGCHK_EN
    logic tag_ok_q, tag_fail_q;
    logic tag_push, tag_eq;

    assign tag_push = push && (textout_kind == 2'd2);
    assign tag_eq   = (textout_r[191:64] == expected_tag);

    always_ff @(posedge eph1) begin
        if (reset) begin
            tag_ok_q   <= 1'b0;
            tag_fail_q <= 1'b0;
        end else begin
            tag_ok_q   <= tag_push & tag_eq;
            tag_fail_q <= tag_push & ~tag_eq;
        end
    end

    assign tag_ok   = tag_ok_q;
    assign tag_fail = tag_fail_q;
`else
    logic unused_tag;

    assign unused_tag = ^expected_tag;
    assign tag_ok     = 1'b0;
    assign tag_fail   = 1'b0;
`endif

endmodule

// File: doc/xoodyak_text_unload.md
XOODYAK_TEXT_UNLOAD -- requirements
Module: xoodyak_text_unload

Interface
REQ-001 SHALL have port eph1, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port textout_r, input, 192, result block from xoodyak_build; bits [191:160] are word 0.
REQ-004 SHALL have port textout_valid, input, 1, one-cycle strobe: textout_r/textout_kind/textout_len valid this cycle.
REQ-005 SHALL have port textout_kind, input, 2, block type: 0 crypt text, 1 squeeze, 2 tag, 3 reserved (treated as 1).
REQ-006 SHALL have port textout_len, input, 3, number of 32-bit words to emit; 1..6 honoured, 0 or 7 mean 6.
REQ-007 SHALL have port expected_tag, input, 128, reference tag for decrypt verification.
REQ-008 SHALL have port dout, output, 32, current output word.
REQ-009 SHALL have port dout_valid, output, 1, dout holds a valid word.
REQ-010 SHALL have port dout_ready, input, 1, consumer accepts word when dout_valid & dout_ready.
REQ-011 SHALL have port dout_last, output, 1, high on the final word of a block.
REQ-012 SHALL have port dout_kind, output, 2, textout_kind of the block being emitted.
REQ-013 SHALL have port fifo_full, output, 1, all 4 block slots occupied.
REQ-014 SHALL have port overflow, output, 1, sticky: a strobe was dropped.
REQ-015 SHALL have ports tag_ok and tag_fail, output, 1 each, one-cycle verification pulses.

Function
REQ-016 SHALL buffer whole blocks in a 4-entry FIFO (192-bit data, kind, len) with 3-bit occupancy count, wrap-around 2-bit read/write pointers.
REQ-017 SHALL push on textout_valid & ~fifo_full, fifo_full derived from the registered count at the start of the cycle.
REQ-018 SHALL drop a strobe arriving while fifo_full, even if the head block's last word pops in that cycle, and set overflow.
REQ-019 SHALL run an unload FSM: IDLE (FIFO empty) -> EMIT (head present) -> IDLE or EMIT after last word accepted.
REQ-020 SHALL present word 0 of a block pushed in cycle N no earlier than cycle N+1 (dout_valid high at N+1 if FIFO was empty).
REQ-021 SHALL emit words most-significant first: word k = head[191-32k -: 32], k = 0..len-1, via a 3-bit word counter.
REQ-022 SHALL hold dout, dout_kind, dout_last stable while dout_valid & ~dout_ready.
REQ-023 SHALL advance the word counter only on dout_valid & dout_ready; on the last word, pop the FIFO and reset counter to 0.
REQ-024 SHALL, on simultaneous push and last-word pop with FIFO not full, keep count unchanged and present the next head on the following cycle without a bubble.
REQ-025 SHALL keep dout_valid low and dout at 0 when the FIFO is empty.

Reset
REQ-026 SHALL on reset clear count, pointers, word counter, FSM to IDLE, overflow, tag_ok, tag_fail; dout_valid, dout_last, fifo_full 0; dout and dout_kind 0.
REQ-027 SHALL discard buffered blocks and any partly emitted block on reset asserted mid-transfer; a strobe coincident with reset is ignored.

Configuration
REQ-028 SHALL compile tag checking in only when macro XOODYAK_TAGCHK_EN is defined.
REQ-029 SHALL, with XOODYAK_TAGCHK_EN, on a push with textout_kind 2, compare textout_r[191:64] to expected_tag and pulse tag_ok (equal) or tag_fail (unequal) in the next cycle; dropped strobes are not checked.
REQ-030 SHALL, without XOODYAK_TAGCHK_EN, keep tag_ok and tag_fail constant 0, ignore expected_tag, and leave all other behaviour unchanged.

Verification
REQ-031 SHALL cover: push kind 0, len 6, textout_r=192'h4d4e4f50...4a4b4c, dout_ready=1 -> words 4d4e4f50, 51525354, ... , 494a4b4c on 6 consecutive cycles, dout_last on 6th.
REQ-032 SHALL cover: len 4 block, dout_ready toggling 1,0,1,0 -> dout stable during stalls, exactly 4 words, dout_last on word 3 only.
REQ-033 SHALL cover: 5 strobes with dout_ready=0 -> fifo_full after 4th, 5th dropped, overflow=1 until reset, then 4 blocks drain in order.
REQ-034 SHALL cover: with XOODYAK_TAGCHK_EN, kind 2 block whose top 128 bits equal expected_tag -> tag_ok pulse 1 cycle; flip one bit -> tag_fail pulse.
REQ-035 SHALL cover: reset asserted after word 2 of a 6-word block -> next cycle dout_valid=0, count=0, overflow=0; new block emits from word 0.
REQ-036 SHALL cover: len 0 block -> 6 words emitted; push coincident with last-word pop at count 1 -> next block word 0 on the following cycle.
